// File: rtl/mac_acumulador.sv
// rtl/mac_acumulador.sv - signed saturating multiply-accumulate over framed operand pairs
module mac_acumulador #(
    parameter int N = 24
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic signed [N-1:0]   Dato_A,
    input  logic signed [N-1:0]   Dato_B,
    input  logic                  Valid_In,
    input  logic                  Last_In,
    output logic                  Ready_In,
    output logic signed [2*N-1:0] Datos_Sum,
    output logic                  Valid_Out,
    input  logic                  Ready_Out,
    output logic                  Saturado
);

    localparam int W = 2 * N;
    localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACUM, DRENA, SALIDA} state_t;

    state_t              state;
    logic signed [W-1:0] a_ext;
    logic signed [W-1:0] b_ext;
    logic signed [W-1:0] prod;
    logic signed [W-1:0] prod_q;
    logic                prod_valid;
    logic                prod_first;
    logic signed [W-1:0] acc;
    logic                sat_flag;
    logic signed [W:0]   sum_ext;
    logic signed [W-1:0] acc_next;
    logic                sat_next;
    logic                xfer;

    // Operands are widened first so the 2N-bit product is exact.
    assign a_ext = {{N{Dato_A[N-1]}}, Dato_A};
    assign b_ext = {{N{Dato_B[N-1]}}, Dato_B};
    assign prod  = a_ext * b_ext;

    assign Ready_In = (state == IDLE) || (state == ACUM);
    assign xfer     = Valid_In && Ready_In;

    always_comb begin
        sum_ext  = {acc[W-1], acc} + {prod_q[W-1], prod_q};
        acc_next = acc;
        sat_next = sat_flag;
        if (prod_valid) begin
            if (prod_first) begin
                acc_next = prod_q;
                sat_next = 1'b0;
            end else if (sum_ext[W] != sum_ext[W-1]) begin
                acc_next = sum_ext[W] ? ACC_MIN : ACC_MAX;
                sat_next = 1'b1;
            end else begin
                acc_next = sum_ext[W-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            prod_q     <= '0;
            prod_valid <= 1'b0;
            prod_first <= 1'b0;
            acc        <= '0;
            sat_flag   <= 1'b0;
            Datos_Sum  <= '0;
            Valid_Out  <= 1'b0;
            Saturado   <= 1'b0;
        end else begin
            prod_valid <= xfer;
            if (xfer) begin
                prod_q     <= prod;
                prod_first <= (state == IDLE);
            end
            acc      <= acc_next;
            sat_flag <= sat_next;

            case (state)
                IDLE: begin
                    if (xfer) state <= Last_In ? DRENA : ACUM;
                end
                ACUM: begin
                    if (xfer && Last_In) state <= DRENA;
                end
                DRENA: begin
                    // Publish once the final product has been folded into acc.
                    if (!prod_valid) begin
                        Datos_Sum <= acc;
                        Saturado  <= sat_flag;
                        Valid_Out <= 1'b1;
                        state     <= SALIDA;
                    end
                end
                SALIDA: begin
                    if (Ready_Out) begin
                        Valid_Out <= 1'b0;
                        Saturado  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_acumulador.sv
// tb/tb_mac_acumulador.sv - randomized and directed checks of mac_acumulador against a frame model
module tb_mac_acumulador;

    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic signed [23:0] Dato_A = '0;
    logic signed [23:0] Dato_B = '0;
    logic               Valid_In = 1'b0;
    logic               Last_In = 1'b0;
    logic               Ready_In;
    logic signed [47:0] Datos_Sum;
    logic               Valid_Out;
    logic               Ready_Out = 1'b0;
    logic               Saturado;

    int     vectors = 0;
    int     miscompares = 0;
    longint fa[16];
    longint fb[16];

    mac_acumulador #(.N(24)) dut (
        .CLK(CLK), .RST(RST), .Dato_A(Dato_A), .Dato_B(Dato_B),
        .Valid_In(Valid_In), .Last_In(Last_In), .Ready_In(Ready_In),
        .Datos_Sum(Datos_Sum), .Valid_Out(Valid_Out), .Ready_Out(Ready_Out),
        .Saturado(Saturado)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Frame result from plain integer arithmetic with explicit clamping.
    task automatic model(input int len, output logic [47:0] es, output logic es_sat);
        longint maxv = 64'sh0000_7FFF_FFFF_FFFF;
        longint minv = -64'sh0000_8000_0000_0000;
        longint acc = 0;
        longint s;
        es_sat = 1'b0;
        for (int i = 0; i < len; i++) begin
            s = (i == 0) ? fa[i] * fb[i] : acc + fa[i] * fb[i];
            if (s > maxv) begin
                acc = maxv;
                es_sat = 1'b1;
            end else if (s < minv) begin
                acc = minv;
                es_sat = 1'b1;
            end else begin
                acc = s;
            end
        end
        es = acc[47:0];
    endtask

    function automatic longint rnd_op();
        logic signed [23:0] t;
        case ($urandom_range(0, 3))
            0: return -64'sd8388608;
            1: return 64'sd8388607;
            default: begin
                t = 24'($urandom);
                return longint'(t);
            end
        endcase
    endfunction

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!Valid_Out && edges < 8) begin
            @(posedge CLK);
            edges++;
            @(negedge CLK);
        end
    endtask

    // Entered and left just after a falling edge.
    task automatic run_frame(input string tag, input int len, input int holdoff, input int bubble_max);
        logic [47:0] es;
        logic        esat;
        int          edges;
        model(len, es, esat);
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, bubble_max)) begin
                Valid_In = 1'b0;
                Ready_Out = 1'($urandom);
                @(negedge CLK);
            end
            Dato_A    = fa[i][23:0];
            Dato_B    = fb[i][23:0];
            Last_In   = (i == len - 1);
            Valid_In  = 1'b1;
            Ready_Out = 1'($urandom);
            check({tag, "_rdy_in"}, 48'(Ready_In), 48'd1);
            @(posedge CLK);
            @(negedge CLK);
        end
        Valid_In  = 1'b0;
        Last_In   = 1'b0;
        Ready_Out = 1'b0;
        check({tag, "_drena_rdy"}, 48'(Ready_In), 48'd0);
        wait_valid(edges);
        check({tag, "_latency"}, 48'(edges), 48'd2);
        check({tag, "_sum"}, Datos_Sum, es);
        check({tag, "_sat"}, 48'(Saturado), 48'(esat));
        repeat (holdoff) begin
            @(posedge CLK);
            @(negedge CLK);
            check({tag, "_hold_v"}, 48'(Valid_Out), 48'd1);
            check({tag, "_hold_sum"}, Datos_Sum, es);
            check({tag, "_hold_rdy"}, 48'(Ready_In), 48'd0);
        end
        Ready_Out = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Ready_Out = 1'b0;
        check({tag, "_done_v"}, 48'(Valid_Out), 48'd0);
        check({tag, "_done_sat"}, 48'(Saturado), 48'd0);
        check({tag, "_done_sum"}, Datos_Sum, es);
        check({tag, "_done_rdy"}, 48'(Ready_In), 48'd1);
    endtask

    initial begin
        int edges;

        repeat (2) @(negedge CLK);
        check("rst_sum", Datos_Sum, 48'd0);
        check("rst_valid", 48'(Valid_Out), 48'd0);
        check("rst_sat", 48'(Saturado), 48'd0);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_rdy", 48'(Ready_In), 48'd1);

        fa[0] = 2;  fb[0] = 3;
        fa[1] = 4;  fb[1] = 5;
        fa[2] = -1; fb[2] = 6;
        run_frame("three_terms", 3, 0, 0);
        check("three_terms_const", Datos_Sum, 48'h0000_0000_0014);

        fa[0] = -8388608; fb[0] = -8388608;
        run_frame("min_sq", 1, 0, 0);
        check("min_sq_const", Datos_Sum, 48'h4000_0000_0000);

        for (int i = 0; i < 4; i++) begin
            fa[i] = -8388608;
            fb[i] = -8388608;
        end
        run_frame("sat_pos", 4, 1, 0);
        check("sat_pos_const", Datos_Sum, 48'h7FFF_FFFF_FFFF);

        for (int i = 0; i < 4; i++) begin
            fa[i] = -8388608;
            fb[i] = 8388607;
        end
        run_frame("sat_neg", 4, 0, 1);
        check("sat_neg_const", Datos_Sum, 48'h8000_0000_0000);

        // Backpressure with the next frame already presented upstream.
        Dato_A = 24'sd7; Dato_B = 24'sd7; Last_In = 1'b1; Valid_In = 1'b1;
        Ready_Out = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        Dato_A = 24'sd1; Dato_B = 24'sd1;
        wait_valid(edges);
        check("bp_latency", 48'(edges), 48'd2);
        repeat (5) begin
            check("bp_sum", Datos_Sum, 48'd49);
            check("bp_valid", 48'(Valid_Out), 48'd1);
            check("bp_rdy", 48'(Ready_In), 48'd0);
            @(posedge CLK);
            @(negedge CLK);
        end
        Ready_Out = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Ready_Out = 1'b0;
        check("bp_release_rdy", 48'(Ready_In), 48'd1);
        check("bp_release_v", 48'(Valid_Out), 48'd0);
        @(posedge CLK);
        @(negedge CLK);
        Valid_In = 1'b0;
        Last_In  = 1'b0;
        wait_valid(edges);
        check("bp_next_latency", 48'(edges), 48'd2);
        check("bp_next_sum", Datos_Sum, 48'd1);
        Ready_Out = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Ready_Out = 1'b0;

        // Partial frame discarded by reset.
        Dato_A = 24'sd3; Dato_B = 24'sd3; Last_In = 1'b0; Valid_In = 1'b1;
        repeat (2) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        Valid_In = 1'b0;
        RST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("midrst_sum", Datos_Sum, 48'd0);
        check("midrst_valid", 48'(Valid_Out), 48'd0);
        check("midrst_sat", 48'(Saturado), 48'd0);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_rdy", 48'(Ready_In), 48'd1);
        fa[0] = 7; fb[0] = 7;
        run_frame("after_rst", 1, 0, 2);
        check("after_rst_const", Datos_Sum, 48'd49);

        for (int i = 0; i < 3; i++) begin
            fa[i] = 3;
            fb[i] = -5;
        end
        run_frame("bubbles", 3, 0, 3);
        check("bubbles_const", Datos_Sum, 48'hFFFF_FFFF_FFD3);

        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                fa[i] = rnd_op();
                fb[i] = rnd_op();
            end
            run_frame("rand", len, $urandom_range(0, 3), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
